// File: rtl/load_store_unit.sv
// Load/store unit between EX/MEM and the word-organised data_memory: sub-word
// read-modify-write, load extraction/extension. Optional LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses.
module load_store_unit #(
  parameter int WIDTH  = 32,
  parameter int VOLUME = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [1:0]                 req_size,
  input  logic                       req_signed,
  input  logic [31:0]                req_addr,
  input  logic [WIDTH-1:0]           req_wdata,
  output logic                       rsp_valid,
  output logic [WIDTH-1:0]           rsp_rdata,
  output logic                       rsp_err,
  output logic [$clog2(VOLUME)-1:0]  mem_addr,
  output logic [WIDTH-1:0]           mem_d_in,
  output logic                       mem_we,
  input  logic [WIDTH-1:0]           mem_d_out
);
  localparam int ADDR_WIDTH = $clog2(VOLUME);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_e;

  state_e                  state_q, state_d;
  logic                    we_q, we_d;
  logic [1:0]              size_q, size_d;
  logic                    signed_q, signed_d;
  logic [ADDR_WIDTH+1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]        wdata_q, wdata_d;
  logic [WIDTH-1:0]        merged_q, merged_d;
  logic [WIDTH-1:0]        rdata_q, rdata_d;

  logic                    misalign;
  logic                    sub_store;
  logic [7:0]              rd_byte;
  logic [15:0]             rd_half;
  logic [WIDTH-1:0]        load_data;
  logic [WIDTH-1:0]        merged;
  logic                    unused_addr;

  // Address bits above the memory are dropped, so accesses wrap.
  assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((size_q == 2'b01) && addr_q[0]) || (size_q[1] && (addr_q[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign sub_store = we_q && !size_q[1];
  assign rd_byte   = mem_d_out[{addr_q[1:0], 3'b000} +: 8];
  assign rd_half   = mem_d_out[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    load_data = mem_d_out;
    merged    = mem_d_out;
    unique case (size_q)
      2'b00: begin
        load_data = {{(WIDTH-8){signed_q & rd_byte[7]}}, rd_byte};
        merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_data = {{(WIDTH-16){signed_q & rd_half[15]}}, rd_half};
        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = ACCESS;
      ACCESS:  state_d = (sub_store && !misalign) ? WRITE : RESP;
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_we    = 1'b0;
    mem_d_in  = '0;
    unique case (state_q)
      IDLE:   req_ready = 1'b1;
      ACCESS: if (we_q && size_q[1] && !misalign) begin
        mem_we   = 1'b1;
        mem_d_in = wdata_q;
      end
      WRITE: begin
        mem_we   = 1'b1;
        mem_d_in = merged_q;
      end
      default: rsp_valid = 1'b1;
    endcase
  end

  assign rsp_err   = rsp_valid & misalign;
  assign rsp_rdata = rdata_q;
  assign mem_addr  = addr_q[ADDR_WIDTH+1:2];

  // Request capture and datapath next state
  always_comb begin
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merged_d = merged_q;
    rdata_d  = rdata_q;
    if (state_q == IDLE && req_valid) begin
      we_d     = req_we;
      size_d   = req_size;
      signed_d = req_signed;
      addr_d   = req_addr[ADDR_WIDTH+1:0];
      wdata_d  = req_wdata;
    end
    if (state_q == ACCESS) begin
      rdata_d = (we_q || misalign) ? '0 : load_data;
      if (sub_store) merged_d = merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
    end else begin
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Randomised scoreboard bench for load_store_unit with a word memory model and
// an arithmetic reference model (honours LSU_MISALIGN_TRAP_EN).
module tb_load_store_unit;
  localparam int WIDTH  = 32;
  localparam int VOLUME = 64;
  localparam int AW     = $clog2(VOLUME);
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic             clk, rst_n;
  logic             req_valid, req_ready, req_we, req_signed;
  logic [1:0]       req_size;
  logic [31:0]      req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid, rsp_err;
  logic [WIDTH-1:0] rsp_rdata;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_d_in, mem_d_out;
  logic             mem_we;

  load_store_unit #(.WIDTH(WIDTH), .VOLUME(VOLUME)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_d_in(mem_d_in),
    .mem_we(mem_we), .mem_d_out(mem_d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_memory stand-in: combinational read, synchronous write
  logic [WIDTH-1:0] mem [VOLUME];
  assign mem_d_out = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_d_in;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];

  logic [31:0] ref_mem [VOLUME];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: lane selection and extension done with plain shifts and masks.
  function automatic void model(input bit we, input logic [1:0] size, input bit sgn,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] rd, output logic err, output int lat);
    int idx, nb, sh;
    logic [63:0] old, lmask, mask, v;
    idx = int'((addr >> 2) % VOLUME);
    nb  = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
    sh  = (nb == 8) ? int'(addr % 4) * 8 : (nb == 16) ? int'(addr[1]) * 16 : 0;
    err = TRAP && ((nb == 16 && addr[0]) || (nb == 32 && addr[1:0] != 2'b00));
    lat = (we && nb < 32 && !err) ? 3 : 2;
    rd  = 32'h0;
    if (err) return;
    old   = {32'h0, ref_mem[idx]};
    lmask = (64'd1 << nb) - 64'd1;
    mask  = lmask << sh;
    if (we) begin
      v = (old & ~mask) | (({32'h0, wd} << sh) & mask);
      ref_mem[idx] = v[31:0];
    end else begin
      v = (old >> sh) & lmask;
      if (sgn && v[nb-1]) v = v | ~lmask;
      rd = v[31:0];
    end
  endfunction

  task automatic issue(input bit we, input logic [1:0] size, input bit sgn,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input bit track, input bit hold);
    int   waited = 0;
    exp_t e;
    @(negedge clk);
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready %b expected 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    if (track) begin
      model(we, size, sgn, addr, wd, e.rdata, e.err, e.lat);
      e.acc = cycle_cnt;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'h1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    check({tag, "_rsp_err"},   32'(rsp_err), 32'h0);
    check({tag, "_mem_we"},    32'(mem_we), 32'h0);
    check({tag, "_mem_addr"},  32'(mem_addr), 32'h0);
    check({tag, "_mem_d_in"},  mem_d_in, 32'h0);
  endtask

  // Monitor: pops one expectation per response pulse
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: rsp_valid 1 with rdata %h, none outstanding", rsp_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("latency", 32'(cycle_cnt - e.acc), 32'(e.lat));
        check("mem_we_in_resp", 32'(mem_we), 32'h0);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < VOLUME; i++) begin
      logic [31:0] r;
      r = $urandom;
      mem[i] <= r;
      ref_mem[i] = r;
    end
    mem[1] <= 32'h8877_66F5; ref_mem[1] = 32'h8877_66F5;
    mem[2] <= 32'hDEAD_BEEF; ref_mem[2] = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed loads on word 1
    issue(1'b0, 2'b00, 1'b1, 32'h4, 32'h0, 1'b1, 1'b0);
    issue(1'b0, 2'b00, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0);
    issue(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 1'b1, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0);

    // Byte store with per-phase checks
    issue(1'b1, 2'b00, 1'b0, 32'h5, 32'h0000_00AB, 1'b1, 1'b0);
    @(negedge clk);
    check("access_mem_we", 32'(mem_we), 32'h0);
    check("access_req_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    check("write_mem_we", 32'(mem_we), 32'h1);
    check("write_req_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    check("resp_rsp_valid", 32'(rsp_valid), 32'h1);
    check("resp_req_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    check("byte_store_word1", mem[1], 32'h8877_ABF5);

    // Back-to-back with req_valid held high across the busy window
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b1, 1'b1);
    issue(1'b0, 2'b00, 1'b1, 32'h7, 32'h0, 1'b1, 1'b0);

    // Reset asserted during WRITE of a half store
    issue(1'b1, 2'b01, 1'b0, 32'h8, 32'h0000_1234, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("abort_write_mem_we", 32'(mem_we), 32'h1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_word2", mem[2], 32'hDEAD_BEEF);

    // Misaligned word store
    issue(1'b1, 2'b10, 1'b0, 32'h6, 32'h1111_1111, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("misalign_word1", mem[1], TRAP ? 32'h8877_ABF5 : 32'h1111_1111);

    // Random traffic, full 32-bit addresses exercise wrap
    for (int n = 0; n < 300; n++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom, $urandom, 1'b1, 1'($urandom_range(0, 1)));
    end
    req_valid = 1'b0;

    begin
      int t = 0;
      while (sb.size() != 0 && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (sb.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
      end
    end
    @(negedge clk);
    for (int i = 0; i < VOLUME; i++) check($sformatf("final_mem[%0d]", i), mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
